// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU pipeline-stage registers: default bundle
// widths, field offsets inside the ID/EX bundles and per-stage control types.
package pipe_pkg;

    localparam int IDEX_DATA_W = 149;
    localparam int IDEX_CTRL_W = 18;

    // ID/EX data bundle field offsets (LSB positions)
    localparam int ADDRC_LSB = 0;    // 5 bits
    localparam int RS_LSB    = 5;    // 5 bits
    localparam int RT_LSB    = 10;   // 5 bits
    localparam int SHAMT_LSB = 15;   // 5 bits
    localparam int BUSA_LSB  = 20;   // 32 bits
    localparam int BUSB_LSB  = 52;   // 32 bits
    localparam int LUOUT_LSB = 84;   // 32 bits
    localparam int CONBA_LSB = 116;  // 32 bits
    localparam int BDS_BIT   = 148;  // branch-delay-slot flag

    // ID/EX control bundle field offsets (LSB positions)
    localparam int MEMTOREG_LSB = 0;   // 2 bits
    localparam int MEMRD_LSB    = 2;
    localparam int MEMWR_LSB    = 3;
    localparam int ALUFUN_LSB   = 4;   // 6 bits
    localparam int ALUSRC2_LSB  = 10;
    localparam int ALUSRC1_LSB  = 11;
    localparam int REGWR_LSB    = 12;
    localparam int REGDST_LSB   = 13;  // 2 bits
    localparam int PCSRC_LSB    = 15;  // 3 bits

    typedef struct packed {
        logic [2:0] pcsrc;
        logic [1:0] regdst;
        logic       regwr;
        logic       alusrc1;
        logic       alusrc2;
        logic [5:0] alufun;
        logic       memwr;
        logic       memrd;
        logic [1:0] memtoreg;
    } idex_ctrl_t;

    typedef struct packed {
        logic       regwr;
        logic       memwr;
        logic       memrd;
        logic [1:0] memtoreg;
    } exmem_ctrl_t;

    typedef struct packed {
        logic       regwr;
        logic [1:0] memtoreg;
    } memwb_ctrl_t;

endpackage

// File: rtl/pipe_stage_skid.sv
// Single-entry skid buffer sitting behind the main stage register.
// Only instantiated when PIPE_REG_SKID_EN is defined.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W     = IDEX_DATA_W,
    parameter int CTRL_W     = IDEX_CTRL_W,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              load,
    input  logic              unload,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              skid_valid,
    output logic [DATA_W-1:0] skid_data,
    output logic [CTRL_W-1:0] skid_ctrl
);

    // Skid entry: emptied by flush or when it moves into main, filled on overflow beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else if (flush || unload) begin
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            if (CLEAR_DATA) skid_data <= '0;
        end else if (load) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            skid_ctrl  <= in_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready handshake, flush (bubble
// insertion), back-pressure hold and saturating stall/flush event counters.
// Define PIPE_REG_SKID_EN to add a one-entry skid buffer (capacity 2, fully
// registered in_ready); without it the stage holds one beat and in_ready is
// combinational from out_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = IDEX_DATA_W,
    parameter int CTRL_W     = IDEX_CTRL_W,
    parameter bit CLEAR_DATA = 1'b0,
    parameter int STAT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt,
    input  logic              cnt_clr
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;

    logic              main_free;
    logic              take_in;
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic [CTRL_W-1:0] src_ctrl;
    logic              stall_inc;
    logic              flush_inc;

    // Main register can take a new beat when empty or when its beat drains
    assign main_free = ~valid_q | out_ready;
    // A beat offered during flush is handshaken but dropped
    assign take_in   = in_valid & in_ready & ~flush;

`ifdef PIPE_REG_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    pipe_stage_skid #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .load       (take_in & ~main_free),
        .unload     (main_free & skid_valid),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .skid_valid (skid_valid),
        .skid_data  (skid_data),
        .skid_ctrl  (skid_ctrl)
    );

    // in_ready depends only on skid state, so no out_ready->in_ready path;
    // a waiting skid beat always refills main before new input (FIFO order)
    assign in_ready  = ~skid_valid;
    assign src_valid = skid_valid | take_in;
    assign src_data  = skid_valid ? skid_data : in_data;
    assign src_ctrl  = skid_valid ? skid_ctrl : in_ctrl;
`else
    assign in_ready  = main_free;
    assign src_valid = take_in;
    assign src_data  = in_data;
    assign src_ctrl  = in_ctrl;
`endif

    // Main register: flush first, then load/empty when free, otherwise hold.
    // Control is zeroed whenever the stage goes empty so no side effect leaks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            if (CLEAR_DATA) data_q <= '0;
        end else if (main_free) begin
            valid_q <= src_valid;
            if (src_valid) begin
                data_q <= src_data;
                ctrl_q <= src_ctrl;
            end else begin
                ctrl_q <= '0;
                if (CLEAR_DATA) data_q <= '0;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_ctrl  = ctrl_q;

    // A flush counts only if it threw away a held or an incoming valid beat
    assign stall_inc = valid_q & ~out_ready;
    assign flush_inc = flush & (valid_q | (in_valid & in_ready));

    // Saturating event counters; clear wins over increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed reset/stream/hold/flush/
// saturation cases, then random traffic against a queue-based scoreboard.
module tb_pipe_stage_reg;

    localparam int DW = 149;
    localparam int CW = 18;
    localparam int SW = 14;
`ifdef PIPE_REG_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready, cnt_clr;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [SW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W     (DW),
        .CTRL_W     (CW),
        .CLEAR_DATA (1'b0),
        .STAT_W     (SW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .cnt_clr   (cnt_clr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: beats currently inside the stage, oldest first
    logic [CW+DW-1:0] sb[$];
    int               cur_occ  = 0;
    bit               exp_in_ready = 1'b0;
    bit               rnd_on   = 1'b0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: mid-cycle, compare DUT against the model and pop transferred beats
    initial begin
        logic [CW+DW-1:0] exp_beat;
        forever begin
            @(negedge clk);
            if (rnd_on) begin
                chk("rnd_out_valid", 256'(out_valid), 256'(cur_occ > 0));
                chk("rnd_in_ready", 256'(in_ready), 256'(exp_in_ready));
                if (!out_valid) chk("rnd_ctrl_zero_when_empty", 256'(out_ctrl), 256'(0));
                if (cur_occ > 0 && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rnd_scoreboard_empty: got beat %0h expected none", out_data);
                    end else begin
                        exp_beat = sb.pop_front();
                        chk("rnd_out_data", 256'(out_data), 256'(exp_beat[DW-1:0]));
                        chk("rnd_out_ctrl", 256'(out_ctrl), 256'(exp_beat[CW+DW-1:DW]));
                    end
                end
            end
        end
    end

    initial begin
        int  next_occ;
        int  model_stall;
        int  model_flush;
        int  seq;
        bit  last_flush, drain, flush_v, accept;

        // 1. reset with a valid all-ones control beat waiting
        reset = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
        in_valid = 1'b1; in_ctrl = 18'h3FFFF; in_data = DW'(5); out_ready = 1'b1;
        step(2);
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_ctrl", 256'(out_ctrl), 256'(0));
        chk("rst_out_data", 256'(out_data), 256'(0));
        chk("rst_stall_cnt", 256'(stall_cnt), 256'(0));
        chk("rst_flush_cnt", 256'(flush_cnt), 256'(0));
        reset = 1'b0;
        step(1);
        chk("first_beat_valid", 256'(out_valid), 256'(1));
        chk("first_beat_data", 256'(out_data), 256'(5));
        chk("first_beat_ctrl", 256'(out_ctrl), 256'(18'h3FFFF));

        // 2. stream 1..4 with out_ready held high
        for (int i = 1; i <= 4; i++) begin
            in_data = DW'(i); in_ctrl = CW'(i);
            step(1);
            chk("stream_data", 256'(out_data), 256'(i));
            chk("stream_valid", 256'(out_valid), 256'(1));
        end
        in_valid = 1'b0;
        step(1);
        chk("stream_empty_valid", 256'(out_valid), 256'(0));
        chk("stream_empty_ctrl", 256'(out_ctrl), 256'(0));
        chk("stream_stall_cnt", 256'(stall_cnt), 256'(0));

        // 3. hold for 3 cycles with beat A inside and beat B offered
        in_valid = 1'b1; in_data = DW'(32'hA); in_ctrl = 18'h2AAAA;
        step(1);
        out_ready = 1'b0; in_data = DW'(32'hB); in_ctrl = 18'h15555;
        #1;
`ifdef PIPE_REG_SKID_EN
        chk("hold_in_ready_skid_free", 256'(in_ready), 256'(1));
`else
        chk("hold_in_ready", 256'(in_ready), 256'(0));
`endif
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("hold_data", 256'(out_data), 256'(32'hA));
            chk("hold_ctrl", 256'(out_ctrl), 256'(18'h2AAAA));
        end
        chk("hold_stall_cnt", 256'(stall_cnt), 256'(3));
        chk("hold_in_ready_full", 256'(in_ready), 256'(0));

        // 4. flush during hold with B still offered
        flush = 1'b1;
        step(1);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 256'(out_valid), 256'(0));
        chk("flush_out_ctrl", 256'(out_ctrl), 256'(0));
        chk("flush_data_kept", 256'(out_data), 256'(32'hA));
        chk("flush_cnt", 256'(flush_cnt), 256'(1));
        chk("flush_stall_cnt", 256'(stall_cnt), 256'(4));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("flush_no_ghost_beat", 256'(out_valid), 256'(0));
        end

        // 5. stall counter saturation, then clear beats a concurrent increment
        in_valid = 1'b1; in_data = DW'(32'hC); in_ctrl = CW'(1);
        step(1);
        in_valid = 1'b0; out_ready = 1'b0;
        step((1 << SW) + 5);
        chk("sat_stall_cnt", 256'(stall_cnt), 256'({SW{1'b1}}));
        cnt_clr = 1'b1;
        step(1);
        chk("clr_stall_cnt", 256'(stall_cnt), 256'(0));
        chk("clr_flush_cnt", 256'(flush_cnt), 256'(0));
        cnt_clr = 1'b0;
        step(1);
        chk("after_clr_stall_cnt", 256'(stall_cnt), 256'(1));

        // 6. random traffic against the scoreboard
        reset = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
        step(1);
        reset = 1'b0;
        sb.delete();
        next_occ = 0; model_stall = 0; model_flush = 0; seq = 0; last_flush = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            #1;
            if (last_flush) sb.delete();
            cur_occ   = next_occ;
            drain     = (i >= 9990);
            flush_v   = !drain && ($urandom_range(0, 9) == 0);
            in_valid  = !drain && ($urandom_range(0, 9) < 7);
            out_ready = drain || ($urandom_range(0, 9) < 6);
            seq++;
            in_data   = {21'($urandom), $urandom, $urandom, $urandom, 32'(seq)};
            in_ctrl   = CW'($urandom);
`ifdef PIPE_REG_SKID_EN
            exp_in_ready = (cur_occ < CAP);
`else
            exp_in_ready = out_ready || (cur_occ == 0);
`endif
            accept = in_valid && exp_in_ready && !flush_v;
            if (accept) sb.push_back({in_ctrl, in_data});
            if (cur_occ > 0 && !out_ready && model_stall < (1 << SW) - 1) model_stall++;
            if (flush_v && (cur_occ > 0 || (in_valid && exp_in_ready)) && model_flush < (1 << SW) - 1)
                model_flush++;
            next_occ   = flush_v ? 0 : cur_occ - ((cur_occ > 0 && out_ready) ? 1 : 0) + (accept ? 1 : 0);
            last_flush = flush_v;
            flush      = flush_v;
            rnd_on     = 1'b1;
        end
        @(posedge clk);
        #1;
        rnd_on = 1'b0;
        flush = 1'b0; in_valid = 1'b0;
        chk("rnd_stall_cnt", 256'(stall_cnt), 256'(model_stall));
        chk("rnd_flush_cnt", 256'(flush_cnt), 256'(model_flush));
        chk("rnd_drained", 256'(out_valid), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
